// File: rtl/pbs_pkg.sv
// Package: pbs_pkg
// Shared definitions for the move table and the attack resolver: the resolver
// FSM state type, the accuracy scale (rolls are drawn out of ACC_SCALE) and the
// damage/accuracy field widths. clamp_roll() folds an out-of-range forced roll
// onto the largest legal roll.
package pbs_pkg;

   localparam int DMG_W = 4;
   localparam int ACC_W = 4;

   // Accuracy is expressed "out of ten"; legal rolls are 0..ACC_SCALE-1.
   localparam logic [ACC_W-1:0] ACC_SCALE = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROLL  = 2'd1,
      ST_APPLY = 2'd2,
      ST_DONE  = 2'd3
   } res_state_e;

   function automatic logic [ACC_W-1:0] clamp_roll(input logic [ACC_W-1:0] r);
      return (r >= ACC_SCALE) ? ACC_SCALE - 1'b1 : r;
   endfunction

endpackage

// File: rtl/pbs_lfsr16.sv
// Module: pbs_lfsr16
// 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifting toward
// the MSB with the feedback bit entering at bit 0.
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high, loads SEED
//   enable  in   advance one step this cycle
//   state   out  current 16-bit register contents
// SEED must be nonzero or the register locks up at all-zeros.
module pbs_lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic [15:0] state
);

   logic [15:0] state_q;
   logic [15:0] state_d;
   logic        feedback;

   // NOTE: every signal assigned in always_comb gets a value on every path
   // (here unconditionally), otherwise synthesis infers a latch.
   always_comb begin
      feedback = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];
      state_d  = enable ? {state_q[14:0], feedback} : state_q;
   end

   // NOTE: sequential state uses non-blocking (<=) so all flops update
   // together at the edge; reset is synchronous, so it sits inside the
   // clocked block and is not in the sensitivity list.
   always_ff @(posedge clk) begin
      if (reset) state_q <= SEED;
      else       state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: rtl/attack_resolver.sv
// Module: attack_resolver
// Resolves one attack: latches the move's damage/accuracy, draws a roll 0..9
// (from the LFSR, redrawing values >= 10, or from a forced debug roll), decides
// hit = roll < accuracy, and subtracts the damage from the opponent HP with
// saturation at zero. FSM: IDLE -> ROLL -> APPLY -> DONE -> IDLE.
// Optional feature macro: ATTACK_RESOLVER_CRIT_EN -- a hit with roll 0 is
// critical and deals double damage. Without it crit is tied low.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   new_battle               reload HP, clear ko, abort any resolve (beats start)
//   start, dmg, accu         resolve request and move parameters (IDLE only)
//   dbg_roll_en, dbg_roll    force the roll (values >= 10 act as 9)
//   busy                     resolve in progress (ROLL/APPLY/DONE)
//   done                     one-cycle result-valid pulse
//   hit, crit, dmg_dealt     result of the last resolve, held until next done
//   opp_hp, ko               opponent HP and sticky knocked-out flag
module attack_resolver
   import pbs_pkg::*;
#(
   parameter int          HP_W      = 8,
   parameter int          MAX_HP    = 40,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            new_battle,
   input  logic            start,
   input  logic [3:0]      dmg,
   input  logic [3:0]      accu,
   input  logic            dbg_roll_en,
   input  logic [3:0]      dbg_roll,
   output logic            busy,
   output logic            done,
   output logic            hit,
   output logic            crit,
   output logic [4:0]      dmg_dealt,
   output logic [HP_W-1:0] opp_hp,
   output logic            ko
);

   localparam logic [HP_W-1:0] HP_FULL = HP_W'(MAX_HP);

   res_state_e       state_q, state_d;
   logic [DMG_W-1:0] dmg_q, dmg_d;
   logic [ACC_W-1:0] accu_q, accu_d;
   logic [ACC_W-1:0] roll_q, roll_d;
   logic             hit_q, hit_d;
   logic             crit_q, crit_d;
   logic [4:0]       dmg_dealt_q, dmg_dealt_d;
   logic [HP_W-1:0]  opp_hp_q, opp_hp_d;
   logic             ko_q, ko_d;

   logic [15:0]      lfsr_state;
   logic [ACC_W-1:0] roll_draw;
   logic             hit_now;
   logic             crit_now;
   logic [4:0]       dmg_eff;
   logic [4:0]       eff;
   logic [HP_W-1:0]  hp_after;
   logic             unused_lfsr_hi;

   pbs_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .enable (1'b1),
      .state  (lfsr_state)
   );

   // Only the low nibble feeds the roll; the rest is the LFSR's own history.
   assign unused_lfsr_hi = ^lfsr_state[15:4];

   // Result datapath, evaluated from the latched move and roll during APPLY.
   always_comb begin
      roll_draw = dbg_roll_en ? clamp_roll(dbg_roll) : lfsr_state[3:0];
      hit_now   = roll_q < accu_q;
`ifdef ATTACK_RESOLVER_CRIT_EN
      crit_now  = hit_now && (roll_q == '0);
      dmg_eff   = crit_now ? {dmg_q, 1'b0} : {1'b0, dmg_q};
`else
      crit_now  = 1'b0;
      dmg_eff   = {1'b0, dmg_q};
`endif
      eff       = hit_now ? dmg_eff : 5'd0;
      hp_after  = (opp_hp_q > HP_W'(eff)) ? opp_hp_q - HP_W'(eff) : '0;
   end

   always_comb begin
      state_d     = state_q;
      dmg_d       = dmg_q;
      accu_d      = accu_q;
      roll_d      = roll_q;
      hit_d       = hit_q;
      crit_d      = crit_q;
      dmg_dealt_d = dmg_dealt_q;
      opp_hp_d    = opp_hp_q;
      ko_d        = ko_q;

      unique case (state_q)
         ST_IDLE: begin
            // A knocked-out opponent cannot be attacked; the request vanishes.
            if (start && !ko_q) begin
               dmg_d   = dmg;
               accu_d  = accu;
               state_d = ST_ROLL;
            end
         end
         ST_ROLL: begin
            // LFSR nibbles 10..15 are rejected and redrawn next cycle so the
            // accepted roll stays uniform over 0..9.
            if (roll_draw < ACC_SCALE) begin
               roll_d  = roll_draw;
               state_d = ST_APPLY;
            end
         end
         ST_APPLY: begin
            hit_d       = hit_now;
            crit_d      = crit_now;
            dmg_dealt_d = eff;
            opp_hp_d    = hp_after;
            if (hp_after == '0) ko_d = 1'b1;
            state_d     = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // A new battle overrides whatever the FSM decided this cycle.
      if (new_battle) begin
         state_d     = ST_IDLE;
         hit_d       = 1'b0;
         crit_d      = 1'b0;
         dmg_dealt_d = 5'd0;
         opp_hp_d    = HP_FULL;
         ko_d        = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         dmg_q       <= '0;
         accu_q      <= '0;
         roll_q      <= '0;
         hit_q       <= 1'b0;
         crit_q      <= 1'b0;
         dmg_dealt_q <= 5'd0;
         opp_hp_q    <= HP_FULL;
         ko_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         dmg_q       <= dmg_d;
         accu_q      <= accu_d;
         roll_q      <= roll_d;
         hit_q       <= hit_d;
         crit_q      <= crit_d;
         dmg_dealt_q <= dmg_dealt_d;
         opp_hp_q    <= opp_hp_d;
         ko_q        <= ko_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign hit       = hit_q;
   assign crit      = crit_q;
   assign dmg_dealt = dmg_dealt_q;
   assign opp_hp    = opp_hp_q;
   assign ko        = ko_q;

endmodule
